// File: rtl/ai_core_rst_seq.sv
// Reset sequencer: asserts all channel resets, then releases them one at a time
// in index order, each release gated by the previous channel's ack or an ack timeout.
module ai_core_rst_seq #(
    parameter int NumChannels = 4,
    parameter int ResetCycles = 5,
    parameter int GapCycles   = 2,
    parameter int AckTimeout  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [NumChannels-1:0] ack_i,
    output logic [NumChannels-1:0] rst_no,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NumChannels-1:0] timeout_o
);

    localparam int CntMaxA = (ResetCycles > GapCycles) ? ResetCycles : GapCycles;
    localparam int CntMax  = (CntMaxA > AckTimeout) ? CntMaxA : AckTimeout;
    localparam int CntW    = $clog2(CntMax + 1);
    localparam int IdxW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    localparam logic [CntW-1:0] AssertLast = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'((GapCycles > 0) ? (GapCycles - 1) : 0);
    localparam logic [CntW-1:0] AckLast    = CntW'(AckTimeout - 1);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumChannels - 1);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_GAP      = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [NumChannels-1:0] rst_q, rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NumChannels-1:0] to_q, to_d;
    logic [IdxW-1:0]        next_idx_s;
    logic                   ack_sel_s;

    assign next_idx_s = idx_q + IdxW'(1);
    assign ack_sel_s  = ack_i[idx_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        done_d  = done_q;
        to_d    = to_q;
        if (req_i) begin
            // Restart dominates every state; timeout flags deliberately survive.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == AssertLast) begin
                        state_d  = ST_WAIT_ACK;
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack on the expiry edge wins, so the flag is set only without one.
                    if (ack_sel_s || (cnt_q == AckLast)) begin
                        if (!ack_sel_s) begin
                            to_d[idx_q] = 1'b1;
                        end else begin
                            to_d = to_q;
                        end
                        cnt_d = '0;
                        if (idx_q == LastIdx) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (GapCycles == 0) begin
                            idx_d             = next_idx_s;
                            rst_d[next_idx_s] = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GapLast) begin
                        state_d           = ST_WAIT_ACK;
                        cnt_d             = '0;
                        idx_d             = next_idx_s;
                        rst_d[next_idx_s] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign rst_no    = rst_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = to_q;

endmodule
